// File: rtl/cache_ctrl_pkg.sv
// Shared definitions for the cache controller: FSM state encoding and the
// default memory timeout.
package cache_ctrl_pkg;

  localparam int unsigned DEF_MEM_TIMEOUT = 64;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_CHECK  = 3'd2,
    ST_MEM_RD = 3'd3,
    ST_MEM_WR = 3'd4,
    ST_FILL   = 3'd5,
    ST_RESP   = 3'd6,
    ST_SETTLE = 3'd7
  } state_t;

  // True for the states that hold a memory request open.
  function automatic logic is_mem_state(input state_t s);
    return (s == ST_MEM_RD) || (s == ST_MEM_WR);
  endfunction

endpackage

// File: rtl/cache_ctrl_sat_counter.sv
// Saturating up-counter; sticks at all-ones.
// Ports: clk, rst (async active-high), inc (count enable), q (count value).
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/cache_ctrl.sv
// Cache controller: sequences a registered-lookup cache and a backing memory
// for one CPU port. Reads look up the cache and fill it on a miss; writes are
// write-through / write-allocate. Memory accesses abort after MEM_TIMEOUT
// cycles without mem_ack. Keeps saturating read hit/miss counters.
// Ports:
//   clk, rst                         clock, async active-high reset
//   cpu_req/we/addr/wdata            CPU request (accepted only when idle)
//   cpu_busy/ack/err/rdata           CPU status and read result
//   cache_addr/we/wdata              cache access; cache_wdata tri-stated unless cache_we
//   cache_rdata/hit                  cache lookup result (registered by the cache)
//   mem_req/we/addr/wdata            memory request, held until ack or timeout
//   mem_rdata/ack                    memory response
//   stat_hits/stat_misses            saturating read hit/miss counters
module cache_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned MEM_TIMEOUT = DEF_MEM_TIMEOUT,
  parameter int unsigned STAT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_busy,
  output logic                  cpu_ack,
  output logic                  cpu_err,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic [ADDR_WIDTH-1:0] cache_addr,
  output logic                  cache_we,
  output logic [DATA_WIDTH-1:0] cache_wdata,
  input  logic [DATA_WIDTH-1:0] cache_rdata,
  input  logic                  cache_hit,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic [STAT_WIDTH-1:0] stat_hits,
  output logic [STAT_WIDTH-1:0] stat_misses
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t                state_q, state_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] fetch_q, fetch_d;
  logic [DATA_WIDTH-1:0] fill_q, fill_d;
  logic                  err_q, err_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic [DATA_WIDTH-1:0] rdata_d;
  logic                  hit_inc, miss_inc;
  logic                  busy_d;

  // State and all registered outputs; outputs are computed from the next
  // state so they are valid throughout the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      fetch_q    <= '0;
      fill_q     <= '0;
      err_q      <= 1'b0;
      wait_q     <= '0;
      cpu_busy   <= 1'b0;
      cpu_ack    <= 1'b0;
      cpu_err    <= 1'b0;
      cpu_rdata  <= '0;
      cache_addr <= '0;
      cache_we   <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      fetch_q    <= fetch_d;
      fill_q     <= fill_d;
      err_q      <= err_d;
      wait_q     <= wait_d;
      cpu_busy   <= busy_d;
      cpu_ack    <= (state_d == ST_RESP);
      cpu_err    <= (state_d == ST_RESP) && err_d;
      cpu_rdata  <= rdata_d;
      cache_addr <= busy_d ? addr_d : '0;
      cache_we   <= (state_d == ST_FILL);
      mem_req    <= is_mem_state(state_d);
      mem_we     <= (state_d == ST_MEM_WR);
      mem_addr   <= busy_d ? addr_d : '0;
      mem_wdata  <= (state_d == ST_MEM_WR) ? wdata_d : '0;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    fetch_d  = fetch_q;
    err_d    = err_q;
    wait_d   = wait_q;
    rdata_d  = cpu_rdata;
    hit_inc  = 1'b0;
    miss_inc = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cpu_req) begin
          we_d    = cpu_we;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          err_d   = 1'b0;
          wait_d  = '0;
          state_d = cpu_we ? ST_MEM_WR : ST_LOOKUP;
        end
      end
      ST_LOOKUP: state_d = ST_CHECK;
      ST_CHECK: begin
        if (cache_hit) begin
          rdata_d = cache_rdata;
          hit_inc = 1'b1;
          state_d = ST_RESP;
        end else begin
          miss_inc = 1'b1;
          wait_d   = '0;
          state_d  = ST_MEM_RD;
        end
      end
      ST_MEM_RD, ST_MEM_WR: begin
        // An ack arriving on the last allowed cycle still completes normally.
        if (mem_ack) begin
          if (!we_q) fetch_d = mem_rdata;
          state_d = ST_FILL;
        end else if (wait_q == WAIT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_FILL: begin
        if (!we_q) rdata_d = fetch_q;
        state_d = ST_RESP;
      end
      ST_RESP:   state_d = ST_SETTLE;
      ST_SETTLE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
    fill_d = we_d ? wdata_d : fetch_d;
  end

  // Cache data bus is shared with the cache's own read path.
  assign cache_wdata = cache_we ? fill_q : {DATA_WIDTH{1'bz}};

  sat_counter #(.WIDTH(STAT_WIDTH)) u_hits (
    .clk (clk),
    .rst (rst),
    .inc (hit_inc),
    .q   (stat_hits)
  );

  sat_counter #(.WIDTH(STAT_WIDTH)) u_misses (
    .clk (clk),
    .rst (rst),
    .inc (miss_inc),
    .q   (stat_misses)
  );

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl with a behavioural cache and memory.
module tb_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [7:0]  cpu_addr, cpu_wdata;
  logic        cpu_busy, cpu_ack, cpu_err;
  logic [7:0]  cpu_rdata;
  logic [7:0]  cache_addr;
  logic        cache_we;
  wire  [7:0]  cache_wdata;
  logic [7:0]  cache_rdata;
  logic        cache_hit;
  logic        mem_req, mem_we;
  logic [7:0]  mem_addr, mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic [15:0] stat_hits, stat_misses;

  cache_ctrl #(
    .ADDR_WIDTH (8),
    .DATA_WIDTH (8),
    .MEM_TIMEOUT(4),
    .STAT_WIDTH (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_busy   (cpu_busy),
    .cpu_ack    (cpu_ack),
    .cpu_err    (cpu_err),
    .cpu_rdata  (cpu_rdata),
    .cache_addr (cache_addr),
    .cache_we   (cache_we),
    .cache_wdata(cache_wdata),
    .cache_rdata(cache_rdata),
    .cache_hit  (cache_hit),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .stat_hits  (stat_hits),
    .stat_misses(stat_misses)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural cache: registered lookup, write on cache_we.
  logic       c_valid [256];
  logic [7:0] c_data  [256];
  always @(posedge clk) begin
    if (cache_we) begin
      c_valid[cache_addr] <= 1'b1;
      c_data[cache_addr]  <= cache_wdata;
    end
    cache_hit   <= c_valid[cache_addr];
    cache_rdata <= c_data[cache_addr];
  end

  // Behavioural memory: acks after mem_wait cycles of mem_req, unless mem_never.
  int         mem_wait  = 0;
  bit         mem_never = 1'b0;
  logic [7:0] mem_val   = 8'h00;
  int         req_cnt   = 0;
  logic [7:0] wr_addr   = 8'h00;
  logic [7:0] wr_data   = 8'h00;
  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (mem_req && !rst) begin
      if (!mem_never && req_cnt == mem_wait) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_val;
        if (mem_we) begin
          wr_addr = mem_addr;
          wr_data = mem_wdata;
        end
      end
      req_cnt++;
    end else begin
      req_cnt = 0;
    end
  end

  // Observations of the last transaction.
  int         c_memreq, c_cachewe, c_ack, n_memreq;
  logic       seen_mem_we, err_at_ack;
  logic [7:0] fill_data, maddr_seen, rdata_at_ack;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one request at cycle 0 and log events until ack (bounded).
  task automatic do_op(input logic we, input logic [7:0] addr, input logic [7:0] wd);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    c_memreq = -1; c_cachewe = -1; c_ack = -1; n_memreq = 0;
    seen_mem_we = 1'b0; err_at_ack = 1'b0; fill_data = 8'h00;
    maddr_seen = 8'h00; rdata_at_ack = 8'h00;
    for (int c = 1; c <= 40 && c_ack < 0; c++) begin
      @(negedge clk);
      cpu_req = 1'b0;
      if (mem_req) begin
        if (c_memreq < 0) begin
          c_memreq   = c;
          maddr_seen = mem_addr;
        end
        n_memreq++;
        if (mem_we) seen_mem_we = 1'b1;
      end
      if (cache_we) begin
        c_cachewe = c;
        fill_data = cache_wdata;
      end
      if (cpu_ack) begin
        c_ack        = c;
        err_at_ack   = cpu_err;
        rdata_at_ack = cpu_rdata;
      end
    end
    if (c_ack < 0) check("ack_timeout", 32'(c_ack), 32'd0);
    @(negedge clk);
  endtask

  int         first_ack, second_ack, acks_after_rst;
  logic       busy_s1, busy_s2;
  logic [15:0] hits1, hits2;
  logic [7:0]  rdata1, rdata2;

  initial begin
    for (int i = 0; i < 256; i++) begin
      c_valid[i] = 1'b0;
      c_data[i]  = 8'h00;
    end
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
    mem_rdata = 8'h00; mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy",   32'(cpu_busy),    32'd0);
    check("rst_ack",    32'(cpu_ack),     32'd0);
    check("rst_memreq", 32'(mem_req),     32'd0);
    check("rst_hits",   32'(stat_hits),   32'd0);
    check("rst_misses", 32'(stat_misses), 32'd0);
    check("rst_rdata",  32'(cpu_rdata),   32'd0);
    check("rst_caddr",  32'(cache_addr),  32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: read miss, W=0
    mem_wait = 0; mem_val = 8'hA5;
    do_op(1'b0, 8'h10, 8'h00);
    check("t1_memreq_cyc", 32'(c_memreq),     32'd3);
    check("t1_mem_addr",   32'(maddr_seen),   32'h10);
    check("t1_cachewe_cyc",32'(c_cachewe),    32'd4);
    check("t1_fill_data",  32'(fill_data),    32'hA5);
    check("t1_ack_cyc",    32'(c_ack),        32'd5);
    check("t1_rdata",      32'(rdata_at_ack), 32'hA5);
    check("t1_err",        32'(err_at_ack),   32'd0);
    check("t1_misses",     32'(stat_misses),  32'd1);
    check("t1_hits",       32'(stat_hits),    32'd0);

    // 2: read hit
    do_op(1'b0, 8'h10, 8'h00);
    check("t2_no_memreq", 32'(c_memreq),     32'hFFFF_FFFF);
    check("t2_ack_cyc",   32'(c_ack),        32'd3);
    check("t2_rdata",     32'(rdata_at_ack), 32'hA5);
    check("t2_hits",      32'(stat_hits),    32'd1);

    // 3: write with W=2, then read it back as a hit
    mem_wait = 2; mem_val = 8'hEE;
    do_op(1'b1, 8'h20, 8'h3C);
    check("t3_mem_we",     32'(seen_mem_we), 32'd1);
    check("t3_ack_cyc",    32'(c_ack),       32'd5);
    check("t3_cachewe_cyc",32'(c_cachewe),   32'd4);
    check("t3_fill_data",  32'(fill_data),   32'h3C);
    check("t3_mem_wdata",  32'(wr_data),     32'h3C);
    check("t3_mem_waddr",  32'(wr_addr),     32'h20);
    check("t3_err",        32'(err_at_ack),  32'd0);
    check("t3_hits",       32'(stat_hits),   32'd1);
    check("t3_misses",     32'(stat_misses), 32'd1);
    do_op(1'b0, 8'h20, 8'h00);
    check("t3_rd_ack_cyc", 32'(c_ack),        32'd3);
    check("t3_rd_rdata",   32'(rdata_at_ack), 32'h3C);
    check("t3_rd_hits",    32'(stat_hits),    32'd2);

    // 4: timeout on a read miss, then ack on the last allowed cycle
    mem_never = 1'b1;
    do_op(1'b0, 8'h40, 8'h00);
    check("t4_memreq_cycles", 32'(n_memreq),     32'd4);
    check("t4_ack_cyc",       32'(c_ack),        32'd7);
    check("t4_err",           32'(err_at_ack),   32'd1);
    check("t4_no_cachewe",    32'(c_cachewe),    32'hFFFF_FFFF);
    check("t4_rdata_kept",    32'(rdata_at_ack), 32'h3C);
    check("t4_misses",        32'(stat_misses),  32'd2);
    mem_never = 1'b0; mem_wait = 3; mem_val = 8'h77;
    do_op(1'b0, 8'h60, 8'h00);
    check("t4b_ack_cyc", 32'(c_ack),        32'd8);
    check("t4b_err",     32'(err_at_ack),   32'd0);
    check("t4b_fill",    32'(fill_data),    32'h77);
    check("t4b_rdata",   32'(rdata_at_ack), 32'h77);
    check("t4b_misses",  32'(stat_misses),  32'd3);

    // 5: reset during MEM_RD
    mem_never = 1'b1;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h50;
    @(negedge clk);
    cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    check("t5_memreq_before", 32'(mem_req), 32'd1);
    rst = 1'b1;
    #1;
    check("t5_memreq_async", 32'(mem_req),     32'd0);
    check("t5_busy",         32'(cpu_busy),    32'd0);
    check("t5_hits",         32'(stat_hits),   32'd0);
    check("t5_misses",       32'(stat_misses), 32'd0);
    check("t5_rdata",        32'(cpu_rdata),   32'd0);
    @(negedge clk);
    rst = 1'b0;
    mem_never = 1'b0; mem_wait = 0;
    acks_after_rst = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (cpu_ack) acks_after_rst++;
    end
    check("t5_no_ack", 32'(acks_after_rst), 32'd0);
    check("t5_idle",   32'(cpu_busy),       32'd0);

    // 6: cpu_req held over two hit reads, hit counter preloaded near saturation
    force dut.u_hits.q = 16'hFFFE;
    @(negedge clk);
    release dut.u_hits.q;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    first_ack = -1; second_ack = -1; busy_s1 = 1'b0; busy_s2 = 1'b1;
    hits1 = 16'h0; hits2 = 16'h0; rdata1 = 8'h0; rdata2 = 8'h0;
    for (int c = 1; c <= 30 && second_ack < 0; c++) begin
      @(negedge clk);
      if (first_ack >= 0 && c == first_ack + 1) busy_s1 = cpu_busy;
      if (first_ack >= 0 && c == first_ack + 2) busy_s2 = cpu_busy;
      if (cpu_ack) begin
        if (first_ack < 0) begin
          first_ack = c; hits1 = stat_hits; rdata1 = cpu_rdata;
        end else begin
          second_ack = c; hits2 = stat_hits; rdata2 = cpu_rdata;
        end
      end
    end
    cpu_req = 1'b0;
    check("t6_first_ack",  32'(first_ack),   32'd3);
    check("t6_second_ack", 32'(second_ack),  32'd8);
    check("t6_settle_busy",32'(busy_s1),     32'd1);
    check("t6_idle_gap",   32'(busy_s2),     32'd0);
    check("t6_hits_sat1",  32'(hits1),       32'hFFFF);
    check("t6_hits_sat2",  32'(hits2),       32'hFFFF);
    check("t6_rdata1",     32'(rdata1),      32'hA5);
    check("t6_rdata2",     32'(rdata2),      32'hA5);
    check("t6_misses",     32'(stat_misses), 32'd0);
    repeat (3) @(negedge clk);
    check("t6_end_idle",   32'(cpu_busy),    32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
